exception_ctrl: RTL and testbench

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exception_ctrl_if.sv | 26 ++
 rtl/exception_ctrl.sv | 102 ++++++++++
 tb/tb_exception_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - decoder/fetch-side signal bundle for exception_ctrl
// master: decoder/fetch side (drives Exc, ERet, EStatus, PC, SysRegSel)
// slave : exception_ctrl (drives ExcAck, PCRedirect, PCTarget, Stall, SysRegData, InHandler)
interface exception_ctrl_if;
    logic        Exc;
    logic        ERet;
    logic [3:0]  EStatus;
    logic [63:0] PC;
    logic [1:0]  SysRegSel;
    logic        ExcAck;
    logic        PCRedirect;
    logic [63:0] PCTarget;
    logic        Stall;
    logic [63:0] SysRegData;
    logic        InHandler;

    modport master (
        output Exc, ERet, EStatus, PC, SysRegSel,
        input  ExcAck, PCRedirect, PCTarget, Stall, SysRegData, InHandler
    );

    modport slave (
        input  Exc, ERet, EStatus, PC, SysRegSel,
        output ExcAck, PCRedirect, PCTarget, Stall, SysRegData, InHandler
    );
endinterface

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - single-level exception/IRQ controller with ELR/ESR/IRQCNT/ERR system registers
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : exception_ctrl_if.slave (exception request/return in, redirect/stall/MRS data out)
module exception_ctrl #(
    parameter logic [63:0] EXC_VECTOR = 64'h00000000000000D8,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    exception_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HANDLER = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t             r_state;
    logic [63:0]        r_elr;
    logic [3:0]         r_esr;
    logic [CNT_W-1:0]   r_irqcnt;
    logic [1:0]         r_err;

    logic               w_is_irq;
    logic               w_take;     // exception accepted from IDLE
    logic               w_ret;      // ERET honoured in HANDLER
    logic               w_dfault;   // synchronous fault while already in HANDLER

    // Only the exact code 0001 is an IRQ; 0000 falls into the fault path.
    assign w_is_irq = (bus.EStatus == 4'b0001);

    // ERET has priority over anything else arriving in HANDLER, so a pending
    // IRQ gets a fresh look from IDLE on the following cycle.
    assign w_take   = reset && (r_state == IDLE) && bus.Exc;
    assign w_ret    = reset && (r_state == HANDLER) && bus.ERet;
    assign w_dfault = reset && (r_state == HANDLER) && !bus.ERet && bus.Exc && !w_is_irq;

    always_comb begin
        bus.ExcAck     = w_take || w_dfault;
        bus.PCRedirect = w_take || w_ret;
        bus.PCTarget   = 64'd0;
        if (w_take) begin
            bus.PCTarget = EXC_VECTOR;
        end else if (w_ret) begin
            bus.PCTarget = r_elr;
        end
        bus.Stall      = reset && (r_state == HALT);
        bus.InHandler  = (r_state == HANDLER);
    end

    always_comb begin
        bus.SysRegData = 64'd0;
        case (bus.SysRegSel)
            2'b00:   bus.SysRegData = r_elr;
            2'b01:   bus.SysRegData = {60'd0, r_esr};
            2'b10:   bus.SysRegData = {{(64-CNT_W){1'b0}}, r_irqcnt};
            default: bus.SysRegData = {62'd0, r_err};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_elr    <= 64'd0;
            r_esr    <= 4'd0;
            r_irqcnt <= '0;
            r_err    <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.Exc) begin
                        r_elr   <= bus.PC;
                        r_esr   <= bus.EStatus;
                        r_state <= HANDLER;
                        if (w_is_irq && (r_irqcnt != {CNT_W{1'b1}})) begin
                            r_irqcnt <= r_irqcnt + 1'b1;
                        end
                    end else if (bus.ERet) begin
                        r_err[1] <= 1'b1;   // spurious ERET, sticky
                    end
                end
                HANDLER: begin
                    if (bus.ERet) begin
                        r_state <= IDLE;
                    end else if (bus.Exc && !w_is_irq) begin
                        // ELR/ESR keep the first fault for post-mortem
                        r_err[0] <= 1'b1;
                        r_state  <= HALT;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed self-checking bench for exception_ctrl
module tb_exception_ctrl;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    exception_ctrl_if bus();

    exception_ctrl #(
        .EXC_VECTOR (64'h00000000000000D8),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // advance one rising edge, land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [1:0] sel, input logic [63:0] exp);
        bus.SysRegSel = sel;
        #1;
        chk(tag, bus.SysRegData, exp);
    endtask

    task automatic idle_in();
        bus.Exc = 1'b0; bus.ERet = 1'b0; bus.EStatus = 4'd0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle_in();
        bus.PC = 64'd0;
        bus.SysRegSel = 2'b00;

        // reset holds outputs low even with requests pending
        bus.Exc = 1'b1; bus.EStatus = 4'd2; bus.ERet = 1'b1;
        step();
        step();
        chk("rst_ack",   bus.ExcAck, 0);
        chk("rst_redir", bus.PCRedirect, 0);
        chk("rst_stall", bus.Stall, 0);
        chk("rst_inh",   bus.InHandler, 0);
        idle_in();
        reset = 1'b1;
        rd("rst_elr", 2'b00, 0);
        rd("rst_cnt", 2'b10, 0);
        rd("rst_err", 2'b11, 0);

        // undefined instruction taken from IDLE
        bus.PC = 64'h40; bus.Exc = 1'b1; bus.EStatus = 4'd2;
        #1;
        chk("undef_ack",   bus.ExcAck, 1);
        chk("undef_redir", bus.PCRedirect, 1);
        chk("undef_tgt",   bus.PCTarget, 64'hD8);
        step();
        idle_in();
        #1;
        chk("hdl_inh",   bus.InHandler, 1);
        chk("hdl_stall", bus.Stall, 0);
        chk("hdl_tgt0",  bus.PCTarget, 0);
        rd("hdl_elr", 2'b00, 64'h40);
        rd("hdl_esr", 2'b01, 64'h2);

        // IRQ masked inside handler
        bus.Exc = 1'b1; bus.EStatus = 4'd1;
        #1;
        chk("mask_ack",   bus.ExcAck, 0);
        chk("mask_redir", bus.PCRedirect, 0);
        step();
        chk("mask_inh", bus.InHandler, 1);
        rd("mask_cnt", 2'b10, 0);

        // ERET wins over masked IRQ in the same cycle
        bus.ERet = 1'b1;
        #1;
        chk("ret_redir", bus.PCRedirect, 1);
        chk("ret_tgt",   bus.PCTarget, 64'h40);
        chk("ret_ack",   bus.ExcAck, 0);
        step();
        bus.ERet = 1'b0; bus.PC = 64'h80;
        #1;
        chk("ret_inh",   bus.InHandler, 0);
        chk("irq_ack",   bus.ExcAck, 1);
        chk("irq_tgt",   bus.PCTarget, 64'hD8);
        step();
        idle_in();
        #1;
        chk("irq_inh", bus.InHandler, 1);
        rd("irq_cnt", 2'b10, 1);
        rd("irq_elr", 2'b00, 64'h80);
        rd("irq_esr", 2'b01, 64'h1);

        // double fault
        bus.PC = 64'h100; bus.Exc = 1'b1; bus.EStatus = 4'd2;
        #1;
        chk("df_ack",   bus.ExcAck, 1);
        chk("df_redir", bus.PCRedirect, 0);
        step();
        idle_in();
        #1;
        chk("df_stall", bus.Stall, 1);
        chk("df_inh",   bus.InHandler, 0);
        rd("df_err", 2'b11, 1);
        rd("df_elr", 2'b00, 64'h80);
        rd("df_esr", 2'b01, 64'h1);

        // HALT ignores everything
        bus.ERet = 1'b1; bus.Exc = 1'b1; bus.EStatus = 4'd1;
        #1;
        chk("halt_redir", bus.PCRedirect, 0);
        chk("halt_ack",   bus.ExcAck, 0);
        step();
        chk("halt_stall", bus.Stall, 1);
        rd("halt_err", 2'b11, 1);
        rd("halt_cnt", 2'b10, 1);

        // reset exits HALT
        reset = 1'b0;
        #1;
        chk("hrst_stall", bus.Stall, 0);
        chk("hrst_ack",   bus.ExcAck, 0);
        step();
        idle_in();
        reset = 1'b1;
        #1;
        chk("hrst_stall2", bus.Stall, 0);
        rd("hrst_elr", 2'b00, 0);
        rd("hrst_esr", 2'b01, 0);
        rd("hrst_cnt", 2'b10, 0);
        rd("hrst_err", 2'b11, 0);

        // 256 IRQ take/return pairs: counter saturates
        bus.SysRegSel = 2'b10;
        for (int i = 0; i < 256; i++) begin
            bus.Exc = 1'b1; bus.EStatus = 4'd1;
            step();
            bus.Exc = 1'b0; bus.ERet = 1'b1;
            step();
            bus.ERet = 1'b0;
            if (i == 253) begin
                #1;
                chk("sat_cnt254", bus.SysRegData, 64'hFE);
            end
        end
        rd("sat_cnt", 2'b10, 64'hFF);
        rd("sat_err", 2'b11, 0);

        // spurious ERET in IDLE
        bus.ERet = 1'b1;
        #1;
        chk("sp_redir", bus.PCRedirect, 0);
        chk("sp_tgt",   bus.PCTarget, 0);
        step();
        bus.ERet = 1'b0;
        chk("sp_inh", bus.InHandler, 0);
        rd("sp_err", 2'b11, 64'h2);

        // EStatus 0000 is a fault: not counted, not masked in handler
        bus.PC = 64'h200; bus.Exc = 1'b1; bus.EStatus = 4'd0;
        step();
        chk("z_inh", bus.InHandler, 1);
        rd("z_cnt", 2'b10, 64'hFF);
        #1;
        chk("z_dfack", bus.ExcAck, 1);
        step();
        idle_in();
        #1;
        chk("z_stall", bus.Stall, 1);
        rd("z_err", 2'b11, 64'h3);
        rd("z_elr", 2'b00, 64'h200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
